// File: rtl/sextium_io_unit_pkg.sv
// sextium_io_unit_pkg: syscall numbers and io-unit state encodings shared with the controller.
package sextium_io_unit_pkg;
    localparam int SYS_HALT  = 0;
    localparam int SYS_READ  = 1;
    localparam int SYS_WRITE = 2;
    typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_PUSH, HALT_DRAIN, HALTED, DONE} io_state_t;
endpackage

// File: rtl/sextium_io_unit_if.sv
// sextium_io_unit_if: controller request/result plus input and output word streams of the io unit.
interface sextium_io_unit_if #(parameter int WIDTH = 16);
    logic             runio;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dr;
    logic             iobusy;
    logic [WIDTH-1:0] io_result;
    logic             halted;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    modport master (
        output runio, acc, dr, in_data, in_valid, out_ready,
        input  iobusy, io_result, halted, in_ready, out_data, out_valid
    );
    modport slave (
        input  runio, acc, dr, in_data, in_valid, out_ready,
        output iobusy, io_result, halted, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sextium_io_fifo.sv
// sextium_io_fifo: synchronous FIFO; a push while full is dropped even if a pop happens in the same cycle.
module sextium_io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clock)
        if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/sextium_io_unit.sv
// sextium_io_unit: syscall execution unit (HALT/READ/WRITE) driven by the controller's runio/iobusy handshake.
module sextium_io_unit
    import sextium_io_unit_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 4
) (
    input logic              clock,
    input logic              reset,
    sextium_io_unit_if.slave io
);
    io_state_t        r_state, w_next;
    logic [WIDTH-1:0] r_dr, r_io_result;
    logic             w_push, w_pop, w_full, w_empty;
    always_ff @(posedge clock)
        r_state <= !reset ? IDLE : w_next;
    // Dispatch straight from acc so the syscall state is entered the cycle after the request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (io.runio) w_next = io.acc == WIDTH'(SYS_HALT)  ? HALT_DRAIN :
                                               io.acc == WIDTH'(SYS_READ)  ? READ_WAIT  :
                                               io.acc == WIDTH'(SYS_WRITE) ? WRITE_PUSH : DONE;
            READ_WAIT:  if (io.in_valid) w_next = DONE;
            WRITE_PUSH: if (!w_full) w_next = DONE;
            HALT_DRAIN: if (w_empty) w_next = HALTED;
            DONE:       if (!io.runio) w_next = IDLE;
            default:    w_next = r_state;
        endcase
    end
    always_comb begin
        io.iobusy   = r_state == IDLE ? io.runio : r_state != DONE;
        io.in_ready = r_state == READ_WAIT;
        io.halted   = r_state == HALTED;
        w_push      = r_state == WRITE_PUSH && !w_full;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dr        <= '0;
            r_io_result <= '0;
        end else begin
            if (r_state == IDLE && io.runio) r_dr <= io.dr;
            if (io.in_ready && io.in_valid) r_io_result <= io.in_data;
        end
    end
    assign w_pop        = io.out_valid && io.out_ready;
    assign io.out_valid = !w_empty;
    assign io.io_result = r_io_result;
    sextium_io_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .i_push (w_push),
        .i_data (r_dr),
        .i_pop  (w_pop),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_head (io.out_data)
    );
endmodule

// File: tb/tb_sextium_io_unit.sv
// tb_sextium_io_unit: directed syscall sequences; popped words are matched against a queue of issued WRITEs.
module tb_sextium_io_unit;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int lat;
    int n;
    logic [WIDTH-1:0] exp_q [$];
    sextium_io_unit_if #(.WIDTH(WIDTH)) io();
    sextium_io_unit #(.WIDTH(WIDTH), .OUT_DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .io(io));
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic do_sys(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d, output int cyc);
        io.runio = 1'b1;
        io.acc = a;
        io.dr = d;
        #1 check("busy_req", io.iobusy, 1);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (io.iobusy && cyc < 20);
        io.runio = 1'b0;
        step();
    endtask
    // A word leaves the FIFO at the next posedge whenever valid and ready are both high here.
    always @(negedge clock) begin : mon
        logic [WIDTH-1:0] e;
        if (reset && io.out_valid && io.out_ready) begin
            e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
            check("pop_data", io.out_data, e);
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        io.runio = 0; io.acc = 0; io.dr = 0;
        io.in_data = 0; io.in_valid = 0; io.out_ready = 0;
        step(); step();
        reset = 1'b1;
        #1;
        check("rst_busy", io.iobusy, 0);
        check("rst_in_ready", io.in_ready, 0);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_result", io.io_result, 0);
        check("rst_halted", io.halted, 0);
        // READ with input arriving three cycles late
        io.acc = 1; io.runio = 1;
        #1;
        check("rd_busy0", io.iobusy, 1);
        check("rd_ready0", io.in_ready, 0);
        step();
        check("rd_ready1", io.in_ready, 1);
        check("rd_busy1", io.iobusy, 1);
        step(); step();
        io.in_valid = 1; io.in_data = 16'h1234;
        #1 check("rd_busy_hs", io.iobusy, 1);
        step();
        check("rd_done_busy", io.iobusy, 0);
        check("rd_done_ready", io.in_ready, 0);
        check("rd_result", io.io_result, 16'h1234);
        io.in_valid = 0; io.in_data = 16'hFFFF; io.runio = 0;
        step();
        check("rd_idle_busy", io.iobusy, 0);
        check("rd_hold", io.io_result, 16'h1234);
        // WRITE burst into a stalled sink
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(16'(i));
            do_sys(2, 16'(i), lat);
            check("wr_lat", lat, 2);
        end
        exp_q.push_back(16'd5);
        io.runio = 1; io.acc = 2; io.dr = 5;
        step(); step(); step();
        check("wr_full_busy", io.iobusy, 1);
        io.out_ready = 1;
        step();
        io.out_ready = 0;
        #1 check("wr_push_blocked", io.iobusy, 1);
        step();
        check("wr5_done", io.iobusy, 0);
        io.runio = 0;
        step();
        io.out_ready = 1;
        repeat (4) step();
        io.out_ready = 0;
        check("wr_drained", io.out_valid, 0);
        check("wr_q_empty", exp_q.size(), 0);
        // unknown syscalls are no-ops
        exp_q.push_back(16'hAAAA);
        do_sys(2, 16'hAAAA, lat);
        io.runio = 1; io.acc = 7; io.dr = 16'h5555;
        step();
        check("nop_busy", io.iobusy, 0);
        step(); step();
        check("nop_done_hold", io.iobusy, 0);
        check("nop_result", io.io_result, 16'h1234);
        check("nop_out_valid", io.out_valid, 1);
        check("nop_out_data", io.out_data, 16'hAAAA);
        io.runio = 0;
        step();
        do_sys(16'h0100, 16'h7777, lat);
        check("nop100_lat", lat, 1);
        check("nop100_halted", io.halted, 0);
        check("nop100_head", io.out_data, 16'hAAAA);
        io.out_ready = 1;
        step();
        io.out_ready = 0;
        check("nop_q_empty", exp_q.size(), 0);
        // push and pop together at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'(10 + i));
            do_sys(2, 16'(10 + i), lat);
        end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            exp_q.push_back(16'(20 + k));
            io.runio = 1; io.acc = 2; io.dr = 16'(20 + k);
            step();
            io.out_ready = 1;
            step();
            io.out_ready = 0;
            check("pp_done", io.iobusy, 0);
            io.runio = 0;
            step();
        end
        io.out_ready = 1;
        n = 0;
        while (io.out_valid && n < 10) begin
            step();
            n++;
        end
        io.out_ready = 0;
        check("pp_count", n, 3);
        check("pp_q_empty", exp_q.size(), 0);
        // reset in the middle of a READ
        io.in_valid = 1; io.in_data = 16'h4321;
        do_sys(1, 0, lat);
        check("rd2_lat", lat, 2);
        io.in_valid = 0;
        check("rd2_result", io.io_result, 16'h4321);
        exp_q.push_back(16'd30);
        do_sys(2, 16'd30, lat);
        exp_q.push_back(16'd31);
        do_sys(2, 16'd31, lat);
        io.runio = 1; io.acc = 1;
        step();
        check("rr_ready", io.in_ready, 1);
        reset = 0;
        step();
        reset = 1;
        exp_q.delete();
        check("rr_out_valid", io.out_valid, 0);
        check("rr_result", io.io_result, 0);
        check("rr_halted", io.halted, 0);
        check("rr_in_ready", io.in_ready, 0);
        check("rr_busy_hi", io.iobusy, 1);
        io.runio = 0;
        #1 check("rr_busy_lo", io.iobusy, 0);
        step();
        // HALT waits for the FIFO to drain, then is terminal
        exp_q.push_back(16'h40);
        do_sys(2, 16'h40, lat);
        exp_q.push_back(16'h41);
        do_sys(2, 16'h41, lat);
        io.out_ready = 1; io.runio = 1; io.acc = 0;
        step();
        check("h_drain_halted", io.halted, 0);
        check("h_drain_busy", io.iobusy, 1);
        step();
        check("h_empty", io.out_valid, 0);
        check("h_empty_halted", io.halted, 0);
        step();
        check("h_halted", io.halted, 1);
        check("h_busy", io.iobusy, 1);
        io.runio = 0;
        #1 check("h_busy_norun", io.iobusy, 1);
        step();
        io.runio = 1; io.acc = 2; io.dr = 9;
        repeat (3) step();
        check("h_still_halted", io.halted, 1);
        check("h_still_busy", io.iobusy, 1);
        check("h_no_push", io.out_valid, 0);
        check("h_q_empty", exp_q.size(), 0);
        io.runio = 0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
